// File: rtl/pc_redirect_ctrl.sv
// PC redirect and hazard control for the 5-stage RV32I pipeline.
// Optional perf counters are enabled with `define PC_REDIRECT_PERF_EN.
module pc_redirect_ctrl #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_op3,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_Z,
    input  logic            ex_S,
    input  logic            ex_U,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_load_use,
    input  logic            fetch_ready,
    output logic [1:0]      pc_src,
    output logic [XLEN-1:0] redirect_pc,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_pending,
    output logic            wait_timeout
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [15:0]     perf_redirects,
    output logic [15:0]     perf_stalls
`endif
);

    typedef enum logic {IDLE = 1'b0, R_WAIT = 1'b1} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [1:0]        src_q;
    logic [XLEN-1:0]   target_q;
    logic [7:0]        wait_cnt_q;
    logic [7:0]        wait_cnt_inc;
    logic              timeout_q;
    logic              cond;
    logic              take;
    logic [1:0]        take_src;

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = ex_Z;
            3'b001:  cond = ~ex_Z;
            3'b100:  cond = ex_S;
            3'b101:  cond = ~ex_S;
            3'b110:  cond = ex_U;
            3'b111:  cond = ~ex_U;
            default: cond = 1'b0;
        endcase
    end

    assign take     = ex_valid & ((ex_branch & cond) | ex_jump);
    assign take_src = (ex_jump & ~ex_op3) ? 2'b10 : 2'b01;

    assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    // Outputs are forced to their reset values while rst_n is low, independent of clk.
    always_comb begin
        state_d     = state_q;
        pc_src      = 2'b00;
        redirect_pc = '0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        pc_src      = take_src;
                        redirect_pc = ex_target;
                        pc_en       = fetch_ready;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (!fetch_ready) state_d = R_WAIT;
                    end else if (id_load_use) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en    = fetch_ready;
                        if_id_en = 1'b1;
                    end
                end
                R_WAIT: begin
                    pc_src      = src_q;
                    redirect_pc = target_q;
                    pc_en       = fetch_ready;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (fetch_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= 2'b00;
            target_q   <= '0;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && take && !fetch_ready) begin
                src_q      <= take_src;
                target_q   <= ex_target;
                wait_cnt_q <= 8'd0;
            end else if (state_q == R_WAIT) begin
                wait_cnt_q <= wait_cnt_inc;
                if (wait_cnt_inc >= MAX_WAIT_C) timeout_q <= 1'b1;
            end
        end
    end

    assign redirect_pending = (state_q == R_WAIT);
    assign wait_timeout     = timeout_q;

`ifdef PC_REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects <= 16'd0;
            perf_stalls    <= 16'd0;
        end else begin
            if (pc_en && pc_src != 2'b00 && perf_redirects != 16'hFFFF)
                perf_redirects <= perf_redirects + 16'd1;
            if (!pc_en && perf_stalls != 16'hFFFF)
                perf_stalls <= perf_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequences PC redirection and pipeline hazard control for the 5-stage RV32I pipeline. Resolves branch/jump outcome from EX-stage flags and selects the next-PC source. Generates PC/IF-ID stall enables and IF-ID/ID-EX flushes. Holds a pending redirect across fetch back-pressure so the target is never lost.

Parameters:
XLEN, 32, PC/target width
MAX_WAIT, 15, fetch-wait cycles before wait_timeout is flagged (max 255)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
ex_valid  in  1  EX stage holds a live instruction
ex_branch  in  1  EX instr is conditional branch
ex_jump  in  1  EX instr is JAL/JALR
ex_op3  in  1  opcode bit 3 (1=JAL, 0=JALR)
ex_funct3  in  3  branch funct3
ex_Z, ex_S, ex_U  in  1 each  ALU zero / signed-less / unsigned-less flags
ex_target  in  XLEN  computed branch/jump target
id_load_use  in  1  load-use hazard detected in ID
fetch_ready  in  1  instruction fetch accepts a new PC this cycle
pc_src  out  2  00=PC+4, 01=branch/JAL target, 10=JALR target
redirect_pc  out  XLEN  target presented with pc_src!=00
pc_en  out  1  PC register write enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  insert bubble in ID/EX
redirect_pending  out  1  FSM in R_WAIT
wait_timeout  out  1  sticky: R_WAIT exceeded MAX_WAIT cycles

Behaviour:
- Condition taken: funct3 000 Z, 001 !Z, 100 S, 101 !S, 110 U, 111 !U. 010/011 never taken.
- take = ex_valid & ((ex_branch & cond) | ex_jump). Source: ex_jump & !ex_op3 -> 10, else 01.
- FSM states IDLE, R_WAIT, reset state IDLE.
- IDLE, take & fetch_ready: pc_src/redirect_pc driven combinationally from EX inputs. pc_en=1, if_id_flush=1, id_ex_flush=1. Stay IDLE. Zero added latency.
- IDLE, take & !fetch_ready: latch src and ex_target into registers and go to R_WAIT. Same cycle: pc_en=0, if_id_flush=1, id_ex_flush=1.
- R_WAIT: pc_src/redirect_pc from latched registers, if_id_flush=1, id_ex_flush=1 every cycle. EX inputs ignored (younger instructions are being flushed). pc_en=fetch_ready. Return to IDLE on the cycle fetch_ready=1.
- wait counter (8-bit): cleared on entry to R_WAIT, increments each R_WAIT cycle, saturates at 255. wait_timeout set when counter reaches MAX_WAIT. wait_timeout is cleared only by reset.
- Load-use (IDLE, no take): pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0, pc_src=00. One cycle per assertion of id_load_use.
- Priority: take/R_WAIT over load-use. A load-use in the same cycle as take is discarded, because the ID instruction is flushed.
- IDLE, no take, no load-use: pc_src=00, pc_en=fetch_ready, if_id_en=1, flushes 0.
- Reset outputs: pc_src=00, redirect_pc=0, pc_en=0, if_id_en=0, both flushes=1, redirect_pending=0, wait_timeout=0. The latched target register and counter are cleared.
- Reset asserted mid-R_WAIT: the pending redirect is dropped and the FSM goes to IDLE immediately.
- if_id_en=1 whenever a flush is asserted, so the flush takes effect.

Optional Feature:
PC_REDIRECT_PERF_EN
- Defined: adds outputs perf_redirects[15:0] and perf_stalls[15:0]. Both are saturating counters, reset to 0.
- perf_redirects increments on each accepted redirect (the cycle pc_en=1 with pc_src!=00).
- perf_stalls increments on each cycle pc_en=0 outside reset.
- Undefined: the ports and counters are absent and the core behaviour is unchanged.

Test Plan:
- BEQ, funct3=000, Z=1, ex_target=0x100, fetch_ready=1 -> same cycle pc_src=01, redirect_pc=0x100, pc_en=1, both flushes=1.
- JALR (jump=1, op3=0, target=0x2A4), fetch_ready low 3 cycles -> redirect_pending=1 for 3 cycles with pc_src=10, redirect_pc=0x2A4, pc_en=0. EX target changes during the wait are ignored. Cycle 4: pc_en=1, then IDLE.
- BLTU funct3=110, U=0; then BGEU funct3=111, U=0 -> first pc_src=00 with no flush, second pc_src=01. funct3=010 with all flags=1 -> never taken.
- id_load_use=1 alone -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle. id_load_use and a taken BNE in the same cycle -> redirect only, if_id_flush=1.
- fetch_ready held low 20 cycles in R_WAIT with MAX_WAIT=15 -> wait_timeout rises when the counter reaches 15 and stays high after exit. rst_n pulse mid-wait -> redirect_pending=0 and outputs at reset values asynchronously.
- With PC_REDIRECT_PERF_EN: 3 redirects plus 5 stall cycles -> perf_redirects=3, perf_stalls=5. Forced count at 0xFFFF -> holds at 0xFFFF.
